// File: rtl/fb_port_arbiter.sv
// Framebuffer single-port RAM arbiter: buffered pixel writes versus display reads.
// Reads win by default; a pending write is forced through after STARVE_MAX denials.
module fb_port_arbiter #(
   parameter int unsigned ADDR_W      = 19,
   parameter int unsigned DATA_W      = 3,
   parameter int unsigned WIDTH       = 640,
   parameter int unsigned HEIGHT      = 480,
   parameter int unsigned WFIFO_DEPTH = 4,
   parameter int unsigned RD_LAT      = 2,
   parameter int unsigned STARVE_MAX  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              px_valid,
   input  logic [DATA_W-1:0] px_data,
   output logic              px_ready,
   input  logic              frame_restart,
   output logic              frame_done,
   output logic              overflow,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_gnt,
   output logic              rd_rvalid,
   output logic [DATA_W-1:0] rd_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_wren,
   input  logic [DATA_W-1:0] ram_q
);

   localparam int unsigned FB_WORDS = WIDTH * HEIGHT;
   localparam int unsigned PTR_W    = $clog2(WFIFO_DEPTH);
   localparam int unsigned CNT_W    = $clog2(WFIFO_DEPTH + 1);
   localparam int unsigned ST_W     = $clog2(STARVE_MAX + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WORDS - 1);

   logic [ADDR_W-1:0] fifo_addr_q [WFIFO_DEPTH];
   logic [ADDR_W-1:0] fifo_addr_d [WFIFO_DEPTH];
   logic [DATA_W-1:0] fifo_data_q [WFIFO_DEPTH];
   logic [DATA_W-1:0] fifo_data_d [WFIFO_DEPTH];
   logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] wp_q, wp_d;
   logic [ST_W-1:0]   starve_q, starve_d;
   logic [RD_LAT-1:0] rv_pipe_q, rv_pipe_d;
   logic              frame_done_q, frame_done_d;
   logic              overflow_q, overflow_d;

   logic fifo_empty, fifo_full, rd_gnt_c, wr_gnt_c, push;

   // Grants are suppressed while rst is high so nothing reaches the RAM mid-reset.
   always_comb begin
      fifo_empty = (cnt_q == '0);
      fifo_full  = (cnt_q == CNT_W'(WFIFO_DEPTH));
      rd_gnt_c   = ~rst & rd_req & (fifo_empty | (starve_q < ST_W'(STARVE_MAX)));
      wr_gnt_c   = ~rst & ~rd_gnt_c & ~fifo_empty;
      push       = px_valid & ~fifo_full;
   end

   always_comb begin
      fifo_addr_d  = fifo_addr_q;
      fifo_data_d  = fifo_data_q;
      wptr_d       = wptr_q;
      rptr_d       = rptr_q;
      cnt_d        = cnt_q;
      wp_d         = wp_q;
      starve_d     = starve_q;
      rv_pipe_d    = RD_LAT'({rv_pipe_q, rd_gnt_c});
      frame_done_d = push & (wp_q == LAST_ADDR);
      overflow_d   = overflow_q | (px_valid & fifo_full);

      if (push) begin
         fifo_addr_d[wptr_q] = wp_q;
         fifo_data_d[wptr_q] = px_data;
         wptr_d              = wptr_q + 1'b1;
      end
      if (wr_gnt_c) begin
         rptr_d = rptr_q + 1'b1;
      end
      case ({push, wr_gnt_c})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase

      // Restart wins over increment; a same-cycle push has already used the old wp.
      if (frame_restart) begin
         wp_d = '0;
      end else if (push) begin
         wp_d = (wp_q == LAST_ADDR) ? '0 : wp_q + 1'b1;
      end

      if (fifo_empty || wr_gnt_c) begin
         starve_d = '0;
      end else if (starve_q < ST_W'(STARVE_MAX)) begin
         starve_d = starve_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q       <= '0;
         rptr_q       <= '0;
         cnt_q        <= '0;
         wp_q         <= '0;
         starve_q     <= '0;
         rv_pipe_q    <= '0;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
         cnt_q        <= cnt_d;
         wp_q         <= wp_d;
         starve_q     <= starve_d;
         rv_pipe_q    <= rv_pipe_d;
         frame_done_q <= frame_done_d;
         overflow_q   <= overflow_d;
      end
   end

   // Entry storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      fifo_addr_q <= fifo_addr_d;
      fifo_data_q <= fifo_data_d;
   end

   always_comb begin
      px_ready   = ~fifo_full;
      frame_done = frame_done_q;
      overflow   = overflow_q;
      rd_gnt     = rd_gnt_c;
      ram_wren   = wr_gnt_c;
      ram_addr   = '0;
      ram_wdata  = '0;
      if (rd_gnt_c) begin
         ram_addr = rd_addr;
      end else if (wr_gnt_c) begin
         ram_addr  = fifo_addr_q[rptr_q];
         ram_wdata = fifo_data_q[rptr_q];
      end
      rd_rvalid = rv_pipe_q[RD_LAT-1] & ~rst;
      rd_rdata  = rd_rvalid ? ram_q : '0;
   end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Self-checking bench for fb_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of the arbitration rules.
module tb_fb_port_arbiter;

   localparam int unsigned ADDR_W = 19;
   localparam int unsigned DATA_W = 3;
   localparam int unsigned WIDTH  = 20;
   localparam int unsigned HEIGHT = 6;
   localparam int unsigned FB     = WIDTH * HEIGHT;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned LAT    = 2;
   localparam int unsigned STARVE = 8;

   logic              clk = 1'b0;
   logic              rst, px_valid, px_ready, frame_restart, frame_done, overflow;
   logic [DATA_W-1:0] px_data, rd_rdata, ram_wdata, ram_q;
   logic              rd_req, rd_gnt, rd_rvalid, ram_wren;
   logic [ADDR_W-1:0] rd_addr, ram_addr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fb_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WIDTH(WIDTH), .HEIGHT(HEIGHT),
      .WFIFO_DEPTH(DEPTH), .RD_LAT(LAT), .STARVE_MAX(STARVE)
   ) dut (
      .clk(clk), .rst(rst), .px_valid(px_valid), .px_data(px_data), .px_ready(px_ready),
      .frame_restart(frame_restart), .frame_done(frame_done), .overflow(overflow),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_rvalid(rd_rvalid),
      .rd_rdata(rd_rdata), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren),
      .ram_q(ram_q)
   );

   // Single-port RAM, address and output registered (two-cycle read latency).
   logic [DATA_W-1:0] mem [FB];
   logic [ADDR_W-1:0] ra_q = '0;
   logic [DATA_W-1:0] rq_q = '0;
   bit                mem_init = 1'b0;
   bit                bd_en = 1'b0;
   logic [ADDR_W-1:0] bd_addr = '0;
   logic [DATA_W-1:0] bd_data = '0;

   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < FB; i++) mem[i] <= DATA_W'($urandom);
         mem_init <= 1'b1;
      end
      if (bd_en) mem[bd_addr] <= bd_data;
      if (ram_wren && ram_addr < FB) mem[ram_addr] <= ram_wdata;
      ra_q <= ram_addr;
      rq_q <= (ra_q < FB) ? mem[ra_q] : '0;
   end
   assign ram_q = rq_q;

   typedef struct packed { logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } wr_t;
   typedef struct packed { int due; logic [DATA_W-1:0] d; } rd_t;
   wr_t mq[$];
   rd_t rdq[$];
   int  m_wp, m_starve, cyc;
   bit  m_ovf, m_fd;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; px_valid = 1'b0; rd_req = 1'b0; frame_restart = 1'b0;
      step(); step();
      rst = 1'b0;
      @(negedge clk);
      checks++; if (px_ready !== 1'b1) begin errors++; $display("FAIL reset_px_ready: got %b want 1", px_ready); end
      checks++; if (rd_gnt !== 1'b0) begin errors++; $display("FAIL reset_rd_gnt: got %b want 0", rd_gnt); end
      checks++; if (rd_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rd_rvalid: got %b want 0", rd_rvalid); end
      checks++; if (rd_rdata !== '0) begin errors++; $display("FAIL reset_rd_rdata: got %0d want 0", rd_rdata); end
      checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL reset_ram_wren: got %b want 0", ram_wren); end
      checks++; if (ram_addr !== '0) begin errors++; $display("FAIL reset_ram_addr: got %0d want 0", ram_addr); end
      checks++; if (ram_wdata !== '0) begin errors++; $display("FAIL reset_ram_wdata: got %0d want 0", ram_wdata); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
      step();
   endtask

   task automatic test_write_only();
      int nw = 0;
      rd_req = 1'b0;
      for (int k = 0; k < 6; k++) begin
         px_valid = (k < 3);
         px_data  = DATA_W'(5 + k);
         @(negedge clk);
         checks++; if (px_ready !== 1'b1) begin errors++; $display("FAIL wr_px_ready: got %b want 1", px_ready); end
         if (ram_wren) begin
            if (nw < 3) begin
               checks++; if (ram_addr !== ADDR_W'(nw)) begin errors++; $display("FAIL wr_addr: got %0d want %0d", ram_addr, nw); end
               checks++; if (ram_wdata !== DATA_W'(5 + nw)) begin errors++; $display("FAIL wr_data: got %0d want %0d", ram_wdata, 5 + nw); end
            end
            nw++;
         end
         step();
      end
      px_valid = 1'b0;
      checks++; if (nw != 3) begin errors++; $display("FAIL wr_count: got %0d want 3", nw); end
   endtask

   task automatic test_read_only();
      bd_addr = ADDR_W'(100); bd_data = DATA_W'(3); bd_en = 1'b1;
      step();
      bd_en = 1'b0;
      rd_req = 1'b1; rd_addr = ADDR_W'(100);
      @(negedge clk);
      checks++; if (rd_gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt: got %b want 1", rd_gnt); end
      checks++; if (ram_addr !== ADDR_W'(100)) begin errors++; $display("FAIL rd_ram_addr: got %0d want 100", ram_addr); end
      checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL rd_ram_wren: got %b want 0", ram_wren); end
      step();
      rd_req = 1'b0;
      @(negedge clk);
      checks++; if (rd_rvalid !== 1'b0) begin errors++; $display("FAIL rd_early_valid: got %b want 0", rd_rvalid); end
      step();
      @(negedge clk);
      checks++; if (rd_rvalid !== 1'b1) begin errors++; $display("FAIL rd_rvalid: got %b want 1", rd_rvalid); end
      checks++; if (rd_rdata !== DATA_W'(3)) begin errors++; $display("FAIL rd_rdata: got %0d want 3", rd_rdata); end
      step();
      @(negedge clk);
      checks++; if (rd_rvalid !== 1'b0) begin errors++; $display("FAIL rd_late_valid: got %b want 0", rd_rvalid); end
      checks++; if (rd_rdata !== '0) begin errors++; $display("FAIL rd_idle_data: got %0d want 0", rd_rdata); end
      step();
   endtask

   task automatic test_starvation();
      int nr = 0;
      bit got = 1'b0;
      rd_req = 1'b1; rd_addr = ADDR_W'($urandom_range(0, FB - 1));
      px_valid = 1'b1; px_data = DATA_W'(2);
      step();
      px_valid = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         if (ram_wren) got = 1'b1;
         else begin
            if (rd_gnt) nr++;
            step();
         end
      end
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL starve_write_seen: got %b want 1", got); end
      checks++; if (nr != STARVE) begin errors++; $display("FAIL starve_reads: got %0d want %0d", nr, STARVE); end
      step();
      @(negedge clk);
      checks++; if (rd_gnt !== 1'b1) begin errors++; $display("FAIL starve_resume: got %b want 1", rd_gnt); end
      step();
      rd_req = 1'b0;
   endtask

   task automatic test_overflow();
      int acc = 0;
      rd_req = 1'b1;
      for (int k = 0; k < 6; k++) begin
         px_valid = 1'b1; px_data = DATA_W'(k);
         @(negedge clk);
         if (px_ready) acc++;
         step();
      end
      px_valid = 1'b0;
      @(negedge clk);
      checks++; if (acc != DEPTH) begin errors++; $display("FAIL ovf_accepted: got %0d want %0d", acc, DEPTH); end
      checks++; if (px_ready !== 1'b0) begin errors++; $display("FAIL ovf_px_ready: got %b want 0", px_ready); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
      step();
      rd_req = 1'b0;
      repeat (8) step();
      @(negedge clk);
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
      checks++; if (px_ready !== 1'b1) begin errors++; $display("FAIL ovf_drained: got %b want 1", px_ready); end
      step();
   endtask

   task automatic test_reset_mid_read();
      rd_req = 1'b1; rd_addr = ADDR_W'(7); px_valid = 1'b1; px_data = DATA_W'(5);
      @(negedge clk);
      checks++; if (rd_gnt !== 1'b1) begin errors++; $display("FAIL rmr_gnt: got %b want 1", rd_gnt); end
      step();
      rd_req = 1'b0; px_valid = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++; if (rd_rvalid !== 1'b0) begin errors++; $display("FAIL rmr_rvalid: got %b want 0", rd_rvalid); end
         checks++; if (rd_rdata !== '0) begin errors++; $display("FAIL rmr_rdata: got %0d want 0", rd_rdata); end
         checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL rmr_wren: got %b want 0", ram_wren); end
         checks++; if (ram_addr !== '0) begin errors++; $display("FAIL rmr_addr: got %0d want 0", ram_addr); end
         checks++; if (px_ready !== 1'b1) begin errors++; $display("FAIL rmr_px_ready: got %b want 1", px_ready); end
         checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rmr_overflow: got %b want 0", overflow); end
         step();
      end
   endtask

   task automatic test_wrap();
      int fd_cnt = 0;
      bit seen_last = 1'b0;
      bit wrap_chk = 1'b0;
      bit any_w = 1'b0;
      logic [ADDR_W-1:0] last_a = '1;
      rst = 1'b1; rd_req = 1'b0;
      step();
      rst = 1'b0;
      for (int k = 0; k < FB + 8; k++) begin
         px_valid = (k <= FB); px_data = DATA_W'($urandom);
         @(negedge clk);
         if (frame_done) fd_cnt++;
         if (ram_wren) begin
            if (seen_last && !wrap_chk) begin
               checks++; if (ram_addr !== '0) begin errors++; $display("FAIL wrap_next_addr: got %0d want 0", ram_addr); end
               wrap_chk = 1'b1;
            end
            if (ram_addr == ADDR_W'(FB - 1)) seen_last = 1'b1;
         end
         step();
      end
      px_valid = 1'b0;
      checks++; if (seen_last !== 1'b1) begin errors++; $display("FAIL wrap_last_seen: got %b want 1", seen_last); end
      checks++; if (wrap_chk !== 1'b1) begin errors++; $display("FAIL wrap_after_last: got %b want 1", wrap_chk); end
      checks++; if (fd_cnt != 1) begin errors++; $display("FAIL wrap_frame_done: got %0d pulses want 1", fd_cnt); end
      for (int k = 0; k < 10; k++) begin
         px_valid = 1'b1; px_data = DATA_W'($urandom);
         step();
      end
      px_valid = 1'b0; frame_restart = 1'b1;
      step();
      frame_restart = 1'b0; px_valid = 1'b1; px_data = DATA_W'($urandom);
      step();
      px_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (ram_wren) begin any_w = 1'b1; last_a = ram_addr; end
         step();
      end
      checks++; if (any_w !== 1'b1) begin errors++; $display("FAIL restart_write_seen: got %b want 1", any_w); end
      checks++; if (last_a !== '0) begin errors++; $display("FAIL restart_addr: got %0d want 0", last_a); end
   endtask

   // Transaction-level model: pending writes in a queue, reads as (due cycle, data).
   task automatic test_random(input int ncyc, input int rd_pct);
      bit rg, wg, ev, push;
      int n;
      logic [ADDR_W-1:0] ea;
      logic [DATA_W-1:0] ed, erd;
      for (int k = 0; k < ncyc; k++) begin
         rst           = (k == 0) || ($urandom_range(0, 399) == 0);
         px_valid      = ($urandom_range(0, 99) < 60);
         px_data       = DATA_W'($urandom);
         rd_req        = ($urandom_range(0, 99) < rd_pct);
         rd_addr       = ADDR_W'($urandom_range(0, FB - 1));
         frame_restart = ($urandom_range(0, 99) < 3);
         @(negedge clk);
         if (rst) begin
            mq.delete(); rdq.delete();
            m_wp = 0; m_starve = 0; m_ovf = 1'b0; m_fd = 1'b0;
         end else begin
            n   = mq.size();
            rg  = rd_req && (n == 0 || m_starve < STARVE);
            wg  = !rg && n > 0;
            ea  = rg ? rd_addr : (wg ? mq[0].a : '0);
            ed  = wg ? mq[0].d : '0;
            ev  = rdq.size() > 0 && rdq[0].due == cyc;
            erd = ev ? rdq[0].d : '0;
            checks++; if (px_ready !== (n < DEPTH)) begin errors++; $display("FAIL rnd_px_ready cyc %0d: got %b want %b", cyc, px_ready, n < DEPTH); end
            checks++; if (rd_gnt !== rg) begin errors++; $display("FAIL rnd_rd_gnt cyc %0d: got %b want %b", cyc, rd_gnt, rg); end
            checks++; if (ram_wren !== wg) begin errors++; $display("FAIL rnd_wren cyc %0d: got %b want %b", cyc, ram_wren, wg); end
            checks++; if (ram_addr !== ea) begin errors++; $display("FAIL rnd_addr cyc %0d: got %0d want %0d", cyc, ram_addr, ea); end
            checks++; if (ram_wdata !== ed) begin errors++; $display("FAIL rnd_wdata cyc %0d: got %0d want %0d", cyc, ram_wdata, ed); end
            checks++; if (rd_rvalid !== ev) begin errors++; $display("FAIL rnd_rvalid cyc %0d: got %b want %b", cyc, rd_rvalid, ev); end
            checks++; if (rd_rdata !== erd) begin errors++; $display("FAIL rnd_rdata cyc %0d: got %0d want %0d", cyc, rd_rdata, erd); end
            checks++; if (frame_done !== m_fd) begin errors++; $display("FAIL rnd_frame_done cyc %0d: got %b want %b", cyc, frame_done, m_fd); end
            checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_overflow cyc %0d: got %b want %b", cyc, overflow, m_ovf); end
            if (ev) void'(rdq.pop_front());
            if (rg) rdq.push_back(rd_t'{cyc + LAT, mem[rd_addr]});
            if (wg) void'(mq.pop_front());
            m_starve = (n == 0 || wg) ? 0 : ((m_starve < STARVE) ? m_starve + 1 : STARVE);
            push = px_valid && n < DEPTH;
            m_fd = push && m_wp == FB - 1;
            if (px_valid && !push) m_ovf = 1'b1;
            if (push) mq.push_back(wr_t'{ADDR_W'(m_wp), px_data});
            if (frame_restart) m_wp = 0;
            else if (push) m_wp = (m_wp + 1) % FB;
         end
         cyc++;
         step();
      end
      rst = 1'b0; px_valid = 1'b0; rd_req = 1'b0; frame_restart = 1'b0;
      step();
   endtask

   initial begin
      rst = 1'b1; px_valid = 1'b0; px_data = '0; frame_restart = 1'b0;
      rd_req = 1'b0; rd_addr = '0; cyc = 0;
      #1;
      test_reset();
      test_write_only();
      test_read_only();
      test_starvation();
      test_overflow();
      test_reset_mid_read();
      test_wrap();
      test_random(3000, 40);
      test_random(2000, 90);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
